note_scheduler: RTL and testbench
=================================

// Module: note_scheduler
// PURPOSE
// - Sequences note events from the song reader onto NUM_PLAYERS parallel note_player instances.
// - Accepts one {note, duration, advance} event per valid/ready handshake.
// - Picks a free player (or steals one), pulses its load_new_note, and tracks per-player busy.
// - For advance events, holds off the next event for `duration` beats. This is how chords and sequencing are expressed.
// PARAMETERS
// - NUM_PLAYERS  3  number of note_player instances driven (2..8)
// - NOTE_W       6  width of note index
// - DUR_W        6  width of duration in beats
// PORTS
// - clk               in   1            system clock; the only clock
// - reset             in   1            asynchronous, active-high; clears all state immediately
// - play_enable       in   1            global play/pause
// - beat              in   1            1/48 s strobe, one cycle wide
// - ev_valid          in   1            event offered by song reader
// - ev_ready          out  1            scheduler can accept event this cycle
// - ev_note           in   NOTE_W       note index; 0 = rest, never allocated
// - ev_duration       in   DUR_W        note length in beats
// - ev_advance        in   1            1: wait ev_duration beats before next accept
// - done_with_note    in   NUM_PLAYERS  per-player done strobe from note_player
// - load_new_note     out  NUM_PLAYERS  one-hot load pulse to players
// - note_to_load      out  NOTE_W       broadcast note, valid while any load_new_note is high
// - duration_to_load  out  DUR_W        broadcast duration, valid with load_new_note
// - players_busy      out  NUM_PLAYERS  player i currently holds a note
// - all_idle          out  1            state==IDLE && players_busy==0
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; load_new_note, players_busy, note_to_load, duration_to_load and wait_cnt = 0.
//   - steal_ptr=0; ev_ready=0 while reset is high.
// - States: IDLE, DISPATCH, WAIT. ev_ready = play_enable && state==IDLE.
// - Accept (IDLE, ev_valid && ev_ready, at cycle t):
//   - Non-rest note: load_new_note = one-hot(target), registered, high during cycle t+1 only.
//     note_to_load/duration_to_load are registered with it. players_busy[target] is set in t+1.
//   - Rest note (ev_note==0): no load pulse, no busy change.
//   - All accepts go to DISPATCH for cycle t+1.
//   - wait_cnt <= ev_duration if ev_advance, else 0.
// - Target selection: lowest-index player with busy==0. If all players are busy, steal player steal_ptr.
//   steal_ptr then increments modulo NUM_PLAYERS; it changes only on a steal.
// - DISPATCH -> WAIT if wait_cnt!=0, else -> IDLE. Event-to-next-ev_ready minimum latency is 2 cycles.
// - WAIT:
//   - wait_cnt decrements on beat && play_enable.
//   - The beat that takes wait_cnt 1->0 moves state to IDLE on the next edge.
//   - While play_enable=0, wait_cnt freezes and state holds.
// - players_busy[i]: cleared on done_with_note[i]. A same-cycle load to i has priority, so busy stays 1.
//   done_with_note on a non-busy player is ignored.
// - play_enable=0:
//   - No new accepts; a DISPATCH already in progress completes its pulse.
//   - players_busy is unchanged; the players themselves pause.
// - ev_duration=0 with advance: treated as no wait.
// - A stolen player receives a new load while busy. This is legal; note_player reloads its duration.
// - Reset asserted mid-DISPATCH or mid-WAIT:
//   - The load pulse drops asynchronously and all state clears.
//   - The interrupted event is lost; the song reader must re-offer it.
// STRUCTURE
// - Package note_pkg:
//   - Constants NOTE_W, DUR_W, REST_NOTE=0, MAX_PLAYERS=8.
//   - Typedef sched_state_t {IDLE, DISPATCH, WAIT}.
// - Sub-module free_player_picker (combinational):
//   - Inputs: busy vector, steal_ptr.
//   - Outputs: one-hot target, steal flag.
// - All flops in the parent use async reset.
// TESTING
// - Reset, then ev {note=20, dur=10, adv=0} -> load_new_note=3'b001 for exactly 1 cycle, note_to_load=20, players_busy=001, ev_ready back high 2 cycles after accept.
// - Three events adv=0 back-to-back, then a fourth -> loads 001, 010, 100; fourth steals player 0 (load 001); next steal hits player 1.
// - Event {note=5, dur=4, adv=1} -> ev_ready stays low until 4 beats pass, high the cycle after the 4th beat; pausing 2 beats mid-wait delays release by 2 beats.
// - done_with_note[1] in the same cycle as load to player 1 -> players_busy[1] stays 1; lone done_with_note[1] clears it and all_idle rises if the others are free.
// - Rest event {note=0, dur=3, adv=1} -> no load pulse, busy unchanged, 3-beat wait observed.
// - Assert reset during WAIT and during a DISPATCH pulse -> all outputs 0 within the same cycle (async); after release ev_ready=1 with play_enable=1.

Source files
------------

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared constants and state type for the note scheduler
package note_pkg;

    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int REST_NOTE   = 0;
    localparam int MAX_PLAYERS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2
    } sched_state_t;

endpackage

// File: rtl/free_player_picker.sv
// rtl/free_player_picker.sv - chooses the lowest free player, or the steal victim when all are busy
module free_player_picker #(
    parameter int NUM_PLAYERS = 3,
    parameter int PTR_W       = 2
)(
    input  logic [NUM_PLAYERS-1:0] busy,
    input  logic [PTR_W-1:0]       steal_ptr,
    output logic [NUM_PLAYERS-1:0] target,
    output logic                   steal
);

    // Scan from the top down so the lowest free index wins; fall back to steal_ptr.
    always_comb begin
        target = '0;
        steal  = 1'b1;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                target    = '0;
                target[i] = 1'b1;
                steal     = 1'b0;
            end
        end
        if (steal) begin
            target = NUM_PLAYERS'(1) << steal_ptr;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - dispatches song events onto parallel note players with beat-based holds
module note_scheduler #(
    parameter int NUM_PLAYERS = 3,
    parameter int NOTE_W      = note_pkg::NOTE_W,
    parameter int DUR_W       = note_pkg::DUR_W
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play_enable,
    input  logic                   beat,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [NOTE_W-1:0]      ev_note,
    input  logic [DUR_W-1:0]       ev_duration,
    input  logic                   ev_advance,
    input  logic [NUM_PLAYERS-1:0] done_with_note,
    output logic [NUM_PLAYERS-1:0] load_new_note,
    output logic [NOTE_W-1:0]      note_to_load,
    output logic [DUR_W-1:0]       duration_to_load,
    output logic [NUM_PLAYERS-1:0] players_busy,
    output logic                   all_idle
);

    import note_pkg::*;

    localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    sched_state_t             state;
    sched_state_t             state_next;
    logic [DUR_W-1:0]         wait_cnt;
    logic [PTR_W-1:0]         steal_ptr;
    logic [NUM_PLAYERS-1:0]   target;
    logic                     steal;
    logic                     accept;
    logic                     do_load;
    logic                     wait_tick;

    free_player_picker #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .PTR_W       (PTR_W)
    ) u_picker (
        .busy      (players_busy),
        .steal_ptr (steal_ptr),
        .target    (target),
        .steal     (steal)
    );

    // Handshake and the qualified beat; reset gating keeps ready/idle low while reset is held.
    assign ev_ready  = play_enable && (state == IDLE) && !reset;
    assign accept    = ev_valid && ev_ready;
    assign do_load   = accept && (ev_note != NOTE_W'(REST_NOTE));
    assign wait_tick = (state == WAIT) && beat && play_enable;
    assign all_idle  = (state == IDLE) && (players_busy == '0) && !reset;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a DISPATCH always lasts one cycle; WAIT ends on the beat that empties wait_cnt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                state_next = (wait_cnt != '0) ? WAIT : IDLE;
            end
            WAIT: begin
                if (wait_tick && (wait_cnt == DUR_W'(1))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Hold counter: loaded on accept, counts qualified beats down while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= ev_advance ? ev_duration : '0;
        end else if (wait_tick && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - DUR_W'(1);
        end
    end

    // One-cycle load pulse plus the broadcast note/duration captured with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_new_note    <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
        end else begin
            load_new_note <= do_load ? target : '0;
            if (do_load) begin
                note_to_load     <= ev_note;
                duration_to_load <= ev_duration;
            end
        end
    end

    // Busy tracking: a load (being accepted or pulsing now) overrides a done strobe to the same player.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            players_busy <= '0;
        end else begin
            players_busy <= (players_busy & ~done_with_note) | load_new_note
                            | (do_load ? target : '0);
        end
    end

    // Round-robin steal victim, advanced only when a steal actually happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steal_ptr <= '0;
        end else if (do_load && steal) begin
            if (steal_ptr == PTR_W'(NUM_PLAYERS - 1)) begin
                steal_ptr <= '0;
            end else begin
                steal_ptr <= steal_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - self-checking bench for note_scheduler
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_enable;
    logic       beat;
    logic       ev_valid;
    logic       ev_ready;
    logic [5:0] ev_note;
    logic [5:0] ev_duration;
    logic       ev_advance;
    logic [2:0] done_with_note;
    logic [2:0] load_new_note;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic [2:0] players_busy;
    logic       all_idle;

    int n_checks = 0;
    int n_fail   = 0;

    note_scheduler #(.NUM_PLAYERS(3), .NOTE_W(6), .DUR_W(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .play_enable      (play_enable),
        .beat             (beat),
        .ev_valid         (ev_valid),
        .ev_ready         (ev_ready),
        .ev_note          (ev_note),
        .ev_duration      (ev_duration),
        .ev_advance       (ev_advance),
        .done_with_note   (done_with_note),
        .load_new_note    (load_new_note),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .players_busy     (players_busy),
        .all_idle         (all_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a scheduler is "idle" when no dispatch cycle is pending and no beats remain owed.
    bit         m_disp;
    int         m_beats;
    logic [2:0] m_busy;
    logic [2:0] m_load;
    logic [2:0] m_load_new;
    logic [2:0] m_snap;
    int         m_sptr;
    int         m_note;
    int         m_dur;
    int         m_tgt;
    bit         m_ready_now;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_disp = 0; m_beats = 0; m_busy = '0; m_load = '0;
            m_sptr = 0; m_note = 0; m_dur = 0;
        end else begin
            m_ready_now = play_enable && !m_disp && (m_beats == 0);
            m_snap      = m_busy;
            if (m_disp) m_disp = 0;
            else if (m_beats > 0 && beat && play_enable) m_beats--;
            for (int i = 0; i < 3; i++)
                if (done_with_note[i] && !m_load[i]) m_busy[i] = 1'b0;
            m_load_new = '0;
            if (m_ready_now && ev_valid) begin
                m_disp  = 1;
                m_beats = ev_advance ? int'(ev_duration) : 0;
                if (ev_note != 0) begin
                    m_tgt = -1;
                    for (int i = 0; i < 3; i++)
                        if (!m_snap[i] && m_tgt < 0) m_tgt = i;
                    if (m_tgt < 0) begin
                        m_tgt  = m_sptr;
                        m_sptr = (m_sptr + 1) % 3;
                    end
                    m_load_new[m_tgt] = 1'b1;
                    m_note = int'(ev_note);
                    m_dur  = int'(ev_duration);
                end
            end
            m_load = m_load_new;
            m_busy = m_busy | m_load_new;
        end
    end

    // Cycle-by-cycle comparison against the model, sampled just after the active edge.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            chk("model_load", int'(load_new_note), int'(m_load));
            if (m_load != '0) begin
                chk("model_note", int'(note_to_load), m_note);
                chk("model_dur", int'(duration_to_load), m_dur);
            end
            chk("model_busy", int'(players_busy), int'(m_busy));
            chk("model_ready", int'(ev_ready), int'(play_enable && !m_disp && m_beats == 0));
            chk("model_idle", int'(all_idle), int'(!m_disp && m_beats == 0 && m_busy == '0));
        end
    end

    // Offer one event; returns at the negedge of the cycle after acceptance (the load pulse cycle).
    task automatic send(input int note, input int dur, input bit adv);
        int k;
        k = 0;
        ev_note = 6'(note); ev_duration = 6'(dur); ev_advance = adv; ev_valid = 1'b1;
        while (!ev_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", int'(ev_ready), 1);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_done(input logic [2:0] d);
        done_with_note = d;
        @(negedge clk);
        done_with_note = '0;
    endtask

    initial begin
        reset = 1'b1; play_enable = 1'b1; beat = 1'b0; ev_valid = 1'b0;
        ev_note = '0; ev_duration = '0; ev_advance = 1'b0; done_with_note = '0;
        #3;
        chk("rst_load", int'(load_new_note), 0);
        chk("rst_busy", int'(players_busy), 0);
        chk("rst_ready", int'(ev_ready), 0);
        chk("rst_note", int'(note_to_load), 0);
        chk("rst_idle", int'(all_idle), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_rst_ready", int'(ev_ready), 1);

        // Single non-advance event
        send(20, 10, 0);
        chk("t1_load", int'(load_new_note), 3'b001);
        chk("t1_note", int'(note_to_load), 20);
        chk("t1_dur", int'(duration_to_load), 10);
        chk("t1_busy", int'(players_busy), 3'b001);
        chk("t1_ready_low", int'(ev_ready), 0);
        @(negedge clk);
        chk("t1_load_gone", int'(load_new_note), 0);
        chk("t1_ready_back", int'(ev_ready), 1);
        pulse_done(3'b001);

        // Fill all players, then two steals
        send(11, 2, 0); chk("t2_load_a", int'(load_new_note), 3'b001);
        send(12, 2, 0); chk("t2_load_b", int'(load_new_note), 3'b010);
        send(13, 2, 0); chk("t2_load_c", int'(load_new_note), 3'b100);
        send(14, 2, 0); chk("t2_steal0", int'(load_new_note), 3'b001);
        chk("t2_steal_note", int'(note_to_load), 14);
        send(15, 2, 0); chk("t2_steal1", int'(load_new_note), 3'b010);
        chk("t2_busy_all", int'(players_busy), 3'b111);
        @(negedge clk);
        pulse_done(3'b111);
        chk("t2_cleared", int'(players_busy), 0);

        // Advance hold of 4 beats
        send(5, 4, 1);
        chk("t3_load", int'(load_new_note), 3'b001);
        @(negedge clk);
        pulse_beat(); pulse_beat(); pulse_beat();
        chk("t3_hold_after3", int'(ev_ready), 0);
        pulse_beat();
        chk("t3_release", int'(ev_ready), 1);
        pulse_done(3'b001);

        // Same hold with a 2-beat pause in the middle
        send(5, 4, 1);
        @(negedge clk);
        pulse_beat(); pulse_beat();
        play_enable = 1'b0;
        pulse_beat(); pulse_beat();
        chk("t3p_paused_busy", int'(players_busy), 3'b001);
        play_enable = 1'b1;
        #1 chk("t3p_hold_resumed", int'(ev_ready), 0);
        pulse_beat();
        chk("t3p_hold_after3", int'(ev_ready), 0);
        pulse_beat();
        chk("t3p_release", int'(ev_ready), 1);

        // Done colliding with a load to the same player
        send(30, 8, 0);
        chk("t4_load", int'(load_new_note), 3'b010);
        pulse_done(3'b010);
        chk("t4_busy_kept", int'(players_busy), 3'b011);
        pulse_done(3'b001);
        chk("t4_busy_p1", int'(players_busy), 3'b010);
        chk("t4_not_idle", int'(all_idle), 0);
        pulse_done(3'b010);
        chk("t4_busy_none", int'(players_busy), 0);
        chk("t4_all_idle", int'(all_idle), 1);

        // Rest with a 3-beat hold
        send(0, 3, 1);
        chk("t5_no_load", int'(load_new_note), 0);
        chk("t5_busy", int'(players_busy), 0);
        @(negedge clk);
        pulse_beat(); pulse_beat();
        chk("t5_hold", int'(ev_ready), 0);
        pulse_beat();
        chk("t5_release", int'(ev_ready), 1);

        // Reset during WAIT
        send(7, 5, 1);
        @(negedge clk);
        pulse_beat();
        #2 reset = 1'b1;
        #1;
        chk("t6w_load", int'(load_new_note), 0);
        chk("t6w_note", int'(note_to_load), 0);
        chk("t6w_dur", int'(duration_to_load), 0);
        chk("t6w_busy", int'(players_busy), 0);
        chk("t6w_ready", int'(ev_ready), 0);
        chk("t6w_idle", int'(all_idle), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t6w_ready_after", int'(ev_ready), 1);

        // Reset during a DISPATCH pulse
        @(negedge clk);
        send(9, 2, 0);
        chk("t6d_load_pre", int'(load_new_note), 3'b001);
        chk("t6d_note_pre", int'(note_to_load), 9);
        #2 reset = 1'b1;
        #1;
        chk("t6d_load", int'(load_new_note), 0);
        chk("t6d_busy", int'(players_busy), 0);
        chk("t6d_ready", int'(ev_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6d_ready_after", int'(ev_ready), 1);
        chk("t6d_idle_after", int'(all_idle), 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
